// File: rtl/vga_scanout_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scanout block.
package vga_scanout_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

  localparam color_t COLOR_UNDERRUN = 12'hF0F;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Half-open window test lo <= c < hi on a raster counter.
  function automatic logic in_win(input logic [9:0] c, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// pix_ce-gated shift register used to align raster control with the frame
// source's fixed response latency. Output is the DEPTH-th stage.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  // Shift one stage per pixel tick; reset flushes to all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else if (pix_ce) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator + pixel-fetch front end. Runs h/v counters, issues
// per-pixel requests, realigns returned data with sync over LAT pixel ticks
// and drives registered pins with sticky underrun detection.
// Optional build macro VGA_TEST_PATTERN_EN adds a pattern_sel input that
// replaces fetched pixels with an internal coordinate pattern.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter int LAT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic       px_req,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  input  color_t     px_data,
  input  logic       px_valid,
  output logic       frame_start,
  output logic       underrun,
  input  logic       underrun_clr,
  output color_t     vga_color,
  output logic       vga_hs,
  output logic       vga_vs
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic       pattern_sel
`endif
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  logic [9:0] h, v;
  logic       active, hs_raw, vs_raw, pat_on;
  logic       d_act, d_hs, d_vs, d_pat;

  // Raster counters: h wraps each line and bumps v, v wraps each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_ce) begin
      if (h == 10'(H_TOTAL - 1)) begin
        h <= '0;
        v <= (v == 10'(V_TOTAL - 1)) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign active = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
  assign hs_raw = in_win(h, 10'(H_VIS + H_FP), 10'(H_VIS + H_FP + H_SYNC));
  assign vs_raw = in_win(v, 10'(V_VIS + V_FP), 10'(V_VIS + V_FP + V_SYNC));

`ifdef VGA_TEST_PATTERN_EN
  assign pat_on = pattern_sel;
`else
  assign pat_on = 1'b0;
`endif

  // rst gating keeps the request strobes quiet while reset is held.
  assign px_req      = pix_ce & ~rst & active & ~pat_on;
  assign frame_start = pix_ce & ~rst & (h == '0) & (v == '0);
  assign px_x        = h;
  assign px_y        = v;

`ifdef VGA_TEST_PATTERN_EN
  // Coordinates and the pattern select ride along only when the pattern
  // generator needs them at the output stage.
  localparam int DW = 24;
  logic [DW-1:0] dl_in, dl_out;
  logic [9:0]    d_x, d_y;
  color_t        pat_color;
  assign dl_in = {pattern_sel, active, hs_raw, vs_raw, h, v};
  assign {d_pat, d_act, d_hs, d_vs, d_x, d_y} = dl_out;
  assign pat_color = '{r: d_x[7:4], g: d_y[7:4], b: {4{d_x[5] ^ d_y[5]}}};
`else
  localparam int DW = 3;
  logic [DW-1:0] dl_in, dl_out;
  color_t        pat_color;
  assign dl_in = {active, hs_raw, vs_raw};
  assign {d_act, d_hs, d_vs} = dl_out;
  assign d_pat = 1'b0;
  assign pat_color = '0;
`endif

  vga_delay_line #(.WIDTH(DW), .DEPTH(LAT)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .din    (dl_in),
    .dout   (dl_out)
  );

  // Pin register: syncs are active-low; colour is blanked outside the
  // delayed visible window; missing data is flagged and painted magenta.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_color <= '0;
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      underrun  <= 1'b0;
    end else if (pix_ce) begin
      vga_hs <= ~d_hs;
      vga_vs <= ~d_vs;
      if (!d_act)        vga_color <= '0;
      else if (d_pat)    vga_color <= pat_color;
      else if (px_valid) vga_color <= px_data;
      else               vga_color <= COLOR_UNDERRUN;
      // Set has priority over clear.
      if (d_act && !d_pat && !px_valid) underrun <= 1'b1;
      else if (underrun_clr)            underrun <= 1'b0;
    end
  end

endmodule
